// File: rtl/pitch_scorer.sv
// Octave-tolerant pitch scorer: folds the reference by octaves toward the sung note, then grades the deviation.
// Optional running total/note counter enabled by defining PITCH_SCORER_TOTAL_EN.
module pitch_scorer #(
    parameter int          FREQ_W     = 15,
    parameter int          MAX_FOLDS  = 8,
    parameter int          TOL0_SH    = 6,
    parameter int          TOL1_SH    = 5,
    parameter int          TOL2_SH    = 4,
    parameter logic [3:0]  SCORE_FULL = 4'd10,
    parameter logic [3:0]  SCORE_T1   = 4'd7,
    parameter logic [3:0]  SCORE_T2   = 4'd5,
    parameter int          TOTAL_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                start,
    input  logic [FREQ_W-1:0]   sung_freq_in,
    input  logic [FREQ_W-1:0]   ref_freq_in,
    output logic                rd_en,
    output logic                busy,
    output logic                score_ready,
    output logic [3:0]          score,
    output logic signed [4:0]   oct_offset,
    output logic                out_of_range,
    input  logic                clr_total,
    output logic [TOTAL_W-1:0]  total_score,
    output logic [TOTAL_W-1:0]  note_count,
    output logic [1:0]          state_dbg
);

    // Handshake: start is a level held by the source until rd_en; rd_en pulses on the
    // accepting edge, score_ready pulses once per result, and both stretch while enable is low.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FOLD  = 2'd1,
        DIFF  = 2'd2,
        SCORE = 2'd3
    } state_t;

    localparam logic [3:0] MAX_F = 4'(MAX_FOLDS);

    state_t              state, state_nx;
    logic [FREQ_W-1:0]   sung_r;
    logic [FREQ_W:0]     ref_r;
    logic [FREQ_W:0]     diff_r;
    logic [FREQ_W:0]     sung_ext;
    logic [3:0]          folds_r;
    logic signed [4:0]   off_r;
    logic                invalid_r;

    logic [FREQ_W+2:0]   sung_x2, sung_x4, ref_x3;
    logic                zero_in, need_up, need_down, limit_hit;
    logic [3:0]          score_nx;

    assign sung_ext  = {1'b0, sung_r};
    assign sung_x2   = {2'b00, sung_r, 1'b0};
    assign sung_x4   = {1'b0, sung_r, 2'b00};
    assign ref_x3    = {2'b00, ref_r} + {1'b0, ref_r, 1'b0};
    assign zero_in   = (sung_r == '0) || (ref_r == '0);
    assign need_up   = sung_x2 > ref_x3;
    assign need_down = sung_x4 < ref_x3;
    assign limit_hit = (need_up || need_down) && (folds_r == MAX_F);

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FOLD;
            FOLD:    if (zero_in || limit_hit || !(need_up || need_down)) state_nx = DIFF;
            DIFF:    state_nx = SCORE;
            SCORE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Tiers are checked tightest first so the best matching band wins.
    always_comb begin
        score_nx = 4'd0;
        if (!invalid_r) begin
            if (diff_r <= (ref_r >> TOL0_SH))      score_nx = SCORE_FULL;
            else if (diff_r <= (ref_r >> TOL1_SH)) score_nx = SCORE_T1;
            else if (diff_r <= (ref_r >> TOL2_SH)) score_nx = SCORE_T2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sung_r       <= '0;
            ref_r        <= '0;
            diff_r       <= '0;
            folds_r      <= '0;
            off_r        <= '0;
            invalid_r    <= 1'b0;
            rd_en        <= 1'b0;
            score_ready  <= 1'b0;
            score        <= '0;
            oct_offset   <= '0;
            out_of_range <= 1'b0;
        end else if (enable) begin
            state       <= state_nx;
            rd_en       <= 1'b0;
            score_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sung_r    <= sung_freq_in;
                        ref_r     <= {1'b0, ref_freq_in};
                        folds_r   <= '0;
                        off_r     <= '0;
                        invalid_r <= 1'b0;
                        rd_en     <= 1'b1;
                    end
                end
                FOLD: begin
                    if (zero_in || limit_hit) begin
                        invalid_r <= 1'b1;
                    end else if (need_up) begin
                        ref_r   <= ref_r << 1;
                        off_r   <= off_r + 5'sd1;
                        folds_r <= folds_r + 4'd1;
                    end else if (need_down) begin
                        ref_r   <= ref_r >> 1;
                        off_r   <= off_r - 5'sd1;
                        folds_r <= folds_r + 4'd1;
                    end
                end
                DIFF: begin
                    diff_r <= (sung_ext >= ref_r) ? (sung_ext - ref_r) : (ref_r - sung_ext);
                end
                SCORE: begin
                    score        <= score_nx;
                    out_of_range <= invalid_r;
                    oct_offset   <= off_r;
                    score_ready  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PITCH_SCORER_TOTAL_EN
    // Clear applies before the add, so a coincident note survives the clear.
    logic [TOTAL_W-1:0] total_base, count_base;
    logic [TOTAL_W:0]   total_sum, count_sum;

    always_comb begin
        total_base = clr_total ? '0 : total_score;
        count_base = clr_total ? '0 : note_count;
        total_sum  = {1'b0, total_base} + {{(TOTAL_W-3){1'b0}}, score};
        count_sum  = {1'b0, count_base} + {{TOTAL_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total_score <= '0;
            note_count  <= '0;
        end else if (enable) begin
            if (score_ready) begin
                total_score <= total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
                note_count  <= count_sum[TOTAL_W] ? '1 : count_sum[TOTAL_W-1:0];
            end else if (clr_total) begin
                total_score <= '0;
                note_count  <= '0;
            end
        end
    end
`else
    logic unused_clr_total;
    assign unused_clr_total = clr_total;
    assign total_score      = '0;
    assign note_count       = '0;
`endif

endmodule

// File: tb/tb_pitch_scorer.sv
// Directed and randomized checks of pitch_scorer against an arithmetic model of octave folding and tier grading.
// Accumulator expectations follow PITCH_SCORER_TOTAL_EN.
module tb_pitch_scorer;

    localparam int MAX_FOLDS = 8;
    localparam int TOT_MAX   = 65535;

    logic               clk = 1'b0;
    logic               rst, enable, start, clr_total;
    logic [14:0]        sung_freq_in, ref_freq_in;
    logic               rd_en, busy, score_ready, out_of_range;
    logic [3:0]         score;
    logic signed [4:0]  oct_offset;
    logic [15:0]        total_score, note_count;
    logic [1:0]         state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];
    int exp_total = 0;
    int exp_count = 0;

    pitch_scorer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .start        (start),
        .sung_freq_in (sung_freq_in),
        .ref_freq_in  (ref_freq_in),
        .rd_en        (rd_en),
        .busy         (busy),
        .score_ready  (score_ready),
        .score        (score),
        .oct_offset   (oct_offset),
        .out_of_range (out_of_range),
        .clr_total    (clr_total),
        .total_score  (total_score),
        .note_count   (note_count),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tot_exp();
`ifdef PITCH_SCORER_TOTAL_EN
        return exp_total;
`else
        return 0;
`endif
    endfunction

    function automatic int cnt_exp();
`ifdef PITCH_SCORER_TOTAL_EN
        return exp_count;
`else
        return 0;
`endif
    endfunction

    // Scale the reference by powers of two until sung lies in [0.75, 1.5] x ref, then grade by percentage bands.
    task automatic model(input int s, input int r, output int sc, output int off, output int oor, output int k);
        int rr, d;
        sc = 0; off = 0; oor = 0; k = 0;
        if (s == 0 || r == 0) begin
            oor = 1;
            return;
        end
        rr = r;
        forever begin
            if (2 * s > 3 * rr || 4 * s < 3 * rr) begin
                if (k == MAX_FOLDS) begin
                    oor = 1;
                    break;
                end
                if (2 * s > 3 * rr) begin
                    rr = rr * 2; off++;
                end else begin
                    rr = rr / 2; off--;
                end
                k++;
            end else begin
                break;
            end
        end
        if (oor != 0) return;
        d = (s > rr) ? s - rr : rr - s;
        if (d <= rr / 64)      sc = 10;
        else if (d <= rr / 32) sc = 7;
        else if (d <= rr / 16) sc = 5;
        else                   sc = 0;
    endtask

    task automatic run_note(input int s, input int r, input int stall_at, input int stall_len, input bit clr_at_ready);
        int sc, off, oor, k, lat;
        bit got;
        logic [3:0] exp_sc;
        model(s, r, sc, off, oor, k);
        exp_q.push_back(4'(sc));
        @(negedge clk);
        sung_freq_in = 15'(s);
        ref_freq_in  = 15'(r);
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rd_en_pulse", rd_en, 1);
        check("busy_high", busy, 1);
        lat = 0;
        got = 0;
        while (!got && lat < 60) begin
            enable = !(lat >= stall_at && lat < stall_at + stall_len);
            @(posedge clk); #1;
            lat++;
            if (lat == 1) check("rd_en_one_cycle", rd_en, 0);
            if (score_ready) got = 1;
        end
        enable = 1'b1;
        check("ready_seen", got, 1);
        exp_sc = exp_q.pop_front();
        if (got) begin
            check("latency", lat, 3 + k + stall_len);
            check("score", score, exp_sc);
            check("oct_offset", oct_offset, off);
            check("out_of_range", out_of_range, oor);
            check("busy_low", busy, 0);
            if (clr_at_ready) begin
                clr_total = 1'b1;
                exp_total = 0;
                exp_count = 0;
            end
            exp_total = (exp_total + sc > TOT_MAX) ? TOT_MAX : exp_total + sc;
            exp_count = (exp_count + 1 > TOT_MAX) ? TOT_MAX : exp_count + 1;
            @(posedge clk); #1;
            clr_total = 1'b0;
            check("ready_one_cycle", score_ready, 0);
            check("score_hold", score, exp_sc);
            check("total_score", total_score, tot_exp());
            check("note_count", note_count, cnt_exp());
        end
    endtask

    initial begin
        int n_ready;
        rst = 1'b1; enable = 1'b1; start = 1'b0; clr_total = 1'b0;
        sung_freq_in = '0; ref_freq_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_rd_en", rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_score_ready", score_ready, 0);
        check("rst_score", score, 0);
        check("rst_offset", oct_offset, 0);
        check("rst_oor", out_of_range, 0);
        check("rst_total", total_score, 0);
        check("rst_count", note_count, 0);
        check("rst_state_idle", state_dbg, 0);

        run_note(440, 440, 1, 0, 0);
        run_note(1760, 440, 1, 0, 0);
        run_note(110, 880, 1, 0, 0);
        run_note(452, 440, 1, 0, 0);
        run_note(465, 440, 1, 0, 0);
        run_note(480, 440, 1, 0, 0);
        run_note(0, 440, 1, 0, 0);
        run_note(32767, 1, 1, 0, 0);
        run_note(1760, 440, 2, 4, 0);

        // Reset mid-fold: nothing must complete and everything returns to zero.
        @(negedge clk);
        sung_freq_in = 15'd32767;
        ref_freq_in  = 15'd1;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_total = 0;
        exp_count = 0;
        check("abort_busy", busy, 0);
        check("abort_score", score, 0);
        check("abort_offset", oct_offset, 0);
        check("abort_oor", out_of_range, 0);
        check("abort_total", total_score, 0);
        check("abort_count", note_count, 0);
        n_ready = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (score_ready) n_ready++;
        end
        check("abort_no_ready", n_ready, 0);

        run_note(440, 440, 1, 0, 0);
        run_note(452, 440, 1, 0, 0);
        run_note(480, 440, 1, 0, 0);
        check("acc_total_17", total_score, tot_exp());
        check("acc_count_3", note_count, cnt_exp());
        run_note(465, 440, 1, 0, 1);
        check("clr_total_5", total_score, tot_exp());
        check("clr_count_1", note_count, cnt_exp());

        for (int i = 0; i < 25; i++) begin
            int r, s, st_at, st_len;
            r = int'($urandom_range(50, 8000));
            case ($urandom_range(0, 3))
                0:       s = int'($urandom_range(0, 32767));
                1:       s = (r << $urandom_range(0, 2)) + int'($urandom_range(0, 40)) - 20;
                2:       s = (r >> $urandom_range(1, 4)) + int'($urandom_range(0, 10)) - 5;
                default: s = r + int'($urandom_range(0, 60)) - 30;
            endcase
            if (s < 0) s = 0;
            if (s > 32767) s = 32767;
            st_at  = int'($urandom_range(1, 2));
            st_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_note(s, r, st_at, st_len, ($urandom_range(0, 7) == 0));
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pitch_scorer.md
# pitch_scorer

Parametrised, multi-cycle pitch scorer for the audio analyzer. It compares a sung frequency against a reference frequency and tolerates octave errors. The reference is folded by octaves until it brackets the sung note. The block then grades the remaining deviation against tolerance tiers that scale with the reference. It sits between the pitch detector/reference FIFO and the score display, and is the generalised successor of the fixed 9-octave comparator.

## Interface

**Parameters**
- `FREQ_W`, default 15: frequency width in Hz, unsigned.
- `MAX_FOLDS`, default 8: maximum octave folds before the note is declared out of range; must be ≤ 15.
- `TOL0_SH`, default 6: full-score band is `|diff| <= ref >> TOL0_SH` (about 1.6 %).
- `TOL1_SH`, default 5: tier-1 band (about 3.1 %).
- `TOL2_SH`, default 4: tier-2 band (about 6.25 %).
- `SCORE_FULL`, default 10; `SCORE_T1`, default 7; `SCORE_T2`, default 5: 4-bit score values.
- `TOTAL_W`, default 16: accumulator width.

**Ports**
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  when low, every register holds, including the FSM.
- `start`  in  1  a new frequency pair is valid; sampled only in IDLE.
- `sung_freq_in`  in  FREQ_W  sung frequency.
- `ref_freq_in`  in  FREQ_W  reference frequency.
- `rd_en`  out  1  one-cycle pulse when the pair is latched; pops the upstream FIFO.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `score_ready`  out  1  one-cycle pulse marking a valid `score`.
- `score`  out  4  result; holds until the next result.
- `oct_offset`  out  5  signed number of octaves the reference was shifted: + means doubled, − means halved.
- `out_of_range`  out  1  zero input or fold limit hit; valid with `score_ready`.
- `clr_total`  in  1  clears the accumulator.
- `total_score`  out  TOTAL_W  running score sum.
- `note_count`  out  TOTAL_W  notes scored.

## Operation

- **Reset.** FSM goes to IDLE. Every output resets to 0, including `total_score` and `note_count`.
- **IDLE.**
  - If `start`: latch `sung_r` and `ref_r` (ref zero-extended to FREQ_W+1 bits), clear the fold counter, pulse `rd_en`, and go to FOLD.
  - `score_ready` is driven low in this state.
- **FOLD.** One decision per cycle, evaluated in this order:
  1. If `sung_r == 0` or `ref_r == 0`: set the invalid flag and go to DIFF.
  2. If `2*sung_r > 3*ref_r`: set `ref_r <= ref_r << 1` and increment the offset.
  3. If `4*sung_r < 3*ref_r`: set `ref_r <= ref_r >> 1` and decrement the offset.
  4. Otherwise: go to DIFF.
  - The folds counter increments on each shift. If a shift is required while folds == MAX_FOLDS, set the invalid flag and go to DIFF.
  - Comparisons use FREQ_W+3-bit products; no overflow is possible.
  - The band [0.75·ref, 1.5·ref] spans one octave, so the loop terminates.
- **DIFF.** Register `diff = |sung_r − ref_r|` and go to SCORE.
- **SCORE.**
  - If invalid: score 0 and `out_of_range` = 1.
  - Otherwise, in this order: `diff <= ref_r>>TOL0_SH` gives SCORE_FULL; `<= ref_r>>TOL1_SH` gives SCORE_T1; `<= ref_r>>TOL2_SH` gives SCORE_T2; anything else gives 0.
  - Update `oct_offset`, pulse `score_ready`, and go to IDLE.
- A `start` arriving while busy is ignored. The upstream source must hold it until `rd_en`.
- **Mid-operation events.** `enable` low freezes the FSM and all outputs; a one-cycle pulse is simply stretched. `rst` mid-operation aborts with no `score_ready` and no accumulator update.

## Timing

- `start` sampled at edge N, with k folds:
  - `rd_en` is high during cycle N..N+1.
  - `score_ready` is high for the single cycle after edge N+3+k.
- Latency is 3 + k cycles: 3 minimum, 3 + MAX_FOLDS maximum. An invalid zero input takes 3 cycles.
- Back-to-back operation: `start` can be accepted in the IDLE cycle that follows `score_ready`.
- `busy` goes high at edge N and low at edge N+3+k.

## Configuration

- Macro: `PITCH_SCORER_TOTAL_EN`.
- **Defined:**
  - On every `score_ready`, `total_score += score` and `note_count += 1`. Both saturate at all-ones.
  - `clr_total` zeroes both counters. If it coincides with `score_ready`, the result is cleared first and the current note is then added.
- **Undefined:** `total_score` and `note_count` are tied to 0 and `clr_total` is ignored. All other behaviour is identical.

## Test plan

- ref=440, sung=440, start at N → `score_ready` after N+3; score=10, offset=0, `out_of_range`=0, `rd_en` pulse at N.
- ref=440, sung=1760 → ref folds 880 then 1760; k=2, ready after N+5, score=10, offset=+2.
- ref=880, sung=110 → ref halves 440, 220, 110; offset=−3, score=10.
- ref=440 with tier checks:
  - sung=452 (diff 12) → 7.
  - sung=465 (diff 25) → 5.
  - sung=480 (diff 40) → 0.
- sung=0 → score 0 and `out_of_range`=1 after N+3. ref=1, sung=32767 → fold limit hit, score 0, `out_of_range`=1. `enable` dropped for 4 cycles mid-FOLD → ready delayed by exactly 4 cycles. `rst` mid-FOLD → no `score_ready`, all outputs 0.
- Macro on:
  - Notes scoring 10, 7, 0 → total=17, count=3.
  - `clr_total` coincident with a fourth note scoring 5 → total=5, count=1.
  - Macro off → total and count stay 0.
